// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit with valid/ready handshake
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   bm_q;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg_main;
    logic               neg_rem;

    // Request decode: op[2] selects divide, op[1:0] selects the variant.
    logic             is_div;
    logic             a_sgn;
    logic             b_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        is_div      = op[2];
        a_sgn       = is_div ? ~op[0] : (op[1:0] != 2'b11);
        b_sgn       = is_div ? ~op[0] : ~op[1];
        a_neg       = a_sgn & a[WIDTH-1];
        b_neg       = b_sgn & b[WIDTH-1];
        a_mag       = a_neg ? (WIDTH'(0) - a) : a;
        b_mag       = b_neg ? (WIDTH'(0) - b) : b;
        div_zero    = is_div & (b == '0);
        div_ovf     = is_div & ~op[0] & (a == MIN_NEG) & (b == '1);
        special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    end

    // acc holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, bm_q};
        mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, bm_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_main ? ((2*WIDTH)'(0) - acc) : acc;
        quo      = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
        if (op_q[2]) begin
            if (op_q[1]) fix_res = neg_rem ? (WIDTH'(0) - rem) : rem;
            else         fix_res = neg_main ? (WIDTH'(0) - quo) : quo;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            bm_q     <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            state  <= S_DONE;
                        end else begin
                            bm_q     <= b_mag;
                            acc      <= {{WIDTH{1'b0}}, a_mag};
                            neg_main <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            cnt      <= '0;
                            state    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= op_q[2] ? div_next : mul_next;
                    if (cnt == LAST_ITER) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    result <= fix_res;
                    state  <= S_DONE;
                end
                default: begin
                    if (out_ready) state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit at WIDTH=32
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is handed over.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %0h, expected no output", result);
                end else begin
                    e = exp_q.pop_front();
                    if (result !== e) begin
                        errors++;
                        $display("FAIL result: got %0h, expected %0h", result, e);
                    end
                end
            end
        end
    end

    task automatic start_req(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] want, input int lat);
        int n;
        logic ir_bad;
        check({name, "_in_ready_before"}, in_ready, 1);
        exp_q.push_back(want);
        start_req(o, x, y);
        n = 0;
        ir_bad = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) ir_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (in_ready) ir_bad = 1'b1;
        check({name, "_latency"}, n, lat);
        check({name, "_in_ready_low"}, ir_bad, 0);
        @(posedge clk); #1;
        check({name, "_back_to_idle"}, in_ready, 1);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        logic seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7_neg3",  MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulh_min",    MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("mulhu_max",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu_m1",   MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        run_op("div_m7_2",    DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem_m7_2",    REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("divu_m7_2",   DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33);
        run_op("div_7_m2",    DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("rem_7_m2",    REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33);
        run_op("remu_100_7",  REMU,   32'd100,      32'd7,        32'd2,        33);
        run_op("divu_by0",    DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run_op("remu_by0",    REMU,   32'd5,        32'd0,        32'd5,        0);
        run_op("div_ovf",     DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("rem_ovf",     REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        exp_q.push_back(32'd14);
        start_req(DIVU, 32'd100, 32'd7);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_latency", n, 33);
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid_hold", out_valid, 1);
            check("bp_result_hold", result, held);
            check("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // Flush at CALC iteration 10.
        start_req(MUL, 32'd9, 32'd9);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", seen, 0);

        // A request alongside flush must be ignored.
        in_valid = 1'b1; op = MUL; a = 32'd2; b = 32'd2; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", in_ready, 1);

        // Asynchronous reset mid-CALC.
        start_req(MUL, 32'd5, 32'd6);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_3_4_after_rst", MUL, 32'd3, 32'd4, 32'd12, 33);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are even integers from 4 to 64.
REQ-002 The block SHALL have the following ports:
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  reset, asynchronous, active-low.
  - in_valid  in  1  request valid.
  - in_ready  out  1  unit can accept a request.
  - op  in  3  operation, RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - a  in  WIDTH  operand A (rs1).
  - b  in  WIDTH  operand B (rs2).
  - flush  in  1  synchronous abort.
  - out_valid  out  1  result valid.
  - out_ready  in  1  consumer accepts result.
  - result  out  WIDTH  result value.
  - busy  out  1  unit not in IDLE.
REQ-003 The block SHALL use one clock, clk; rst_n SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL implement a four-state FSM: IDLE, CALC, FIX, DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 in CALC, FIX and DONE; out_valid SHALL be 1 only in DONE.
REQ-006 A request SHALL be accepted on the rising edge where in_valid=1 and in_ready=1.
  - op, a and b SHALL be latched on that edge.
  - Input changes after acceptance SHALL NOT affect the result.
REQ-007 On acceptance of a normal request, the FSM SHALL move IDLE->CALC.
  - CALC SHALL run exactly WIDTH iterations, one per edge, tracked by an iteration counter.
  - Then CALC->FIX, then FIX->DONE.
  - out_valid SHALL therefore first be 1 after the (WIDTH+1)th edge following the accept edge.
REQ-008 Multiply SHALL use radix-2 shift-add on operand magnitudes, giving a 2*WIDTH-bit product.
  - Sign handling: MUL and MULH treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
  - FIX SHALL negate the product when the operand signs differ.
  - MUL SHALL return the low WIDTH bits; MULH, MULHSU and MULHU SHALL return the high WIDTH bits.
REQ-009 Divide SHALL use restoring division on magnitudes.
  - DIV/REM are signed; DIVU/REMU are unsigned.
  - FIX SHALL negate the quotient when the operand signs differ, and negate the remainder when the dividend is negative.
  - Quotients SHALL truncate toward zero.
REQ-010 Special cases SHALL be detected at acceptance; the FSM SHALL go IDLE->DONE directly, with out_valid=1 after the accept edge:
  - Divide by zero (b=0): DIV/DIVU result = all ones; REM/REMU result = a.
  - Signed overflow (DIV/REM, a = most-negative value, b = all ones): DIV result = a; REM result = 0.
REQ-011 In DONE, result and out_valid SHALL hold stable until an edge with out_ready=1.
  - That edge SHALL move the FSM DONE->IDLE.
  - There is no same-edge accept of a new request (in_ready=0 in DONE).
REQ-012 flush=1 on any edge SHALL force the FSM to IDLE, clear out_valid and discard the operation.
  - A result in DONE SHALL be dropped.
  - A request presented on the same edge as flush SHALL NOT be accepted.
  - flush SHALL have priority over every other transition.
REQ-013 result SHALL retain its last value outside DONE; it is only meaningful when out_valid=1.
REQ-014 All arithmetic SHALL be modulo 2^WIDTH on the returned word; no overflow or status flags SHALL be produced.

Reset
REQ-015 While rst_n=0, the outputs SHALL be:
  - FSM = IDLE, in_ready=1, out_valid=0, busy=0.
  - result=0 and the iteration counter = 0.
  - All internal operand, accumulator and quotient registers = 0.
REQ-016 Reset asserted mid-operation SHALL abort the operation immediately (asynchronously), with no result produced.
REQ-017 After rst_n rises, the first rising edge SHALL be able to accept a request.

Verification (WIDTH=32)
REQ-018 The bench SHALL cover: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid first high 33 edges after accept; in_ready=0 throughout.
REQ-019 The bench SHALL cover: MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-020 The bench SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU on the same operands -> 0x7FFFFFFC.
REQ-021 The bench SHALL cover special cases, each with out_valid high 1 edge after accept:
  - DIVU a=5, b=0 -> 0xFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
REQ-022 The bench SHALL cover backpressure: hold out_ready=0 for 5 cycles in DONE -> result, out_valid=1 and in_ready=0 stay stable; out_ready=1 -> IDLE on the next edge.
REQ-023 The bench SHALL cover aborts:
  - flush at CALC iteration 10 -> IDLE and in_ready=1 on the next edge, no out_valid.
  - rst_n pulsed low mid-CALC -> in_ready=1 and out_valid=0 immediately.
  - A following MUL 3*4 -> result 12.
